// File: rtl/hpdl_pkg.sv
// Shared constants, state encoding and pin mapping for the HPDL-1414 write scheduler.
package hpdl_pkg;

  localparam int unsigned NUM_POS = 16;
  localparam int unsigned POS_W   = 4;
  localparam int unsigned CHR_W   = 7;
  localparam int unsigned DEV_W   = 2;
  localparam int unsigned DIG_W   = 2;

  localparam logic [CHR_W-1:0] CARET_CHR = 7'h5F;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_SETUP,
    ST_PULSE,
    ST_HOLD
  } state_e;

  typedef struct packed {
    logic [DEV_W-1:0] dev;
    logic [DIG_W-1:0] a;
  } pins_t;

  // Upper bits pick the device; the digit select is inverted (digit 0 is rightmost).
  function automatic pins_t pos_to_pins(input logic [POS_W-1:0] idx);
    pins_t p;
    p.dev = idx[3:2];
    p.a   = ~idx[1:0];
    return p;
  endfunction

endpackage

// File: rtl/hpdl_write_sched_if.sv
// Buffer, caret and HPDL pin bundle between the scheduler and its surroundings.
interface hpdl_write_sched_if;
  import hpdl_pkg::*;

  logic                 mark_valid;
  logic [POS_W-1:0]     mark_addr;
  logic                 caret_en;
  logic [POS_W-1:0]     caret_pos;
  logic                 caret_strobe;
  logic [POS_W-1:0]     buf_raddr;
  logic [CHR_W-1:0]     buf_rdata;
  logic [CHR_W-1:0]     HPDL_D;
  logic [DIG_W-1:0]     HPDL_A;
  logic [NUM_POS/4-1:0] HPDL_WR_N;
  logic                 busy;

  modport slave (
    input  mark_valid, mark_addr, caret_en, caret_pos, caret_strobe, buf_rdata,
    output buf_raddr, HPDL_D, HPDL_A, HPDL_WR_N, busy
  );

  modport master (
    output mark_valid, mark_addr, caret_en, caret_pos, caret_strobe, buf_rdata,
    input  buf_raddr, HPDL_D, HPDL_A, HPDL_WR_N, busy
  );

endinterface

// File: rtl/hpdl_rr_pick.sv
// Combinational round-robin picker: first set mask bit searching upward from i_last+1.
module hpdl_rr_pick
  import hpdl_pkg::*;
(
  input  logic [NUM_POS-1:0] i_mask,
  input  logic [POS_W-1:0]   i_last,
  output logic               o_found_c,
  output logic [POS_W-1:0]   o_idx_c
);

  logic [POS_W-1:0] w_cand;

  always_comb begin
    o_found_c = 1'b0;
    o_idx_c   = '0;
    w_cand    = '0;
    for (int unsigned i = 1; i <= NUM_POS; i++) begin
      w_cand = POS_W'(i_last + POS_W'(i));
      if (!o_found_c && i_mask[w_cand]) begin
        o_found_c = 1'b1;
        o_idx_c   = w_cand;
      end
    end
  end

endmodule

// File: rtl/hpdl_write_sched.sv
// On-demand HPDL-1414 write scheduler: dirty-mask tracking, round-robin selection
// and a timed setup/pulse/hold write cycle per stale position.
module hpdl_write_sched
  import hpdl_pkg::*;
#(
  parameter int unsigned SETUP_CYC   = 2,
  parameter int unsigned PULSE_CYC   = 4,
  parameter int unsigned HOLD_CYC    = 2,
  parameter int unsigned REFRESH_CYC = 2**20
) (
  input logic               CLK,
  input logic               RESET,
  hpdl_write_sched_if.slave bus
);

  localparam int unsigned MAX_CYC = (SETUP_CYC > PULSE_CYC)
      ? ((SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC)
      : ((PULSE_CYC > HOLD_CYC) ? PULSE_CYC : HOLD_CYC);
  localparam int unsigned CNT_W = $clog2(MAX_CYC + 1);
  localparam int unsigned WR_W  = NUM_POS / 4;

  state_e               r_state, w_state_next;
  logic [CNT_W-1:0]     r_cnt, w_cnt_next;
  logic [NUM_POS-1:0]   r_dirty, w_dirty_next, w_set, w_clr;
  logic [POS_W-1:0]     r_last;
  logic [POS_W-1:0]     r_buf_raddr, w_raddr_next;
  logic [CHR_W-1:0]     r_hpdl_d, w_chr;
  logic [DIG_W-1:0]     r_hpdl_a;
  logic [DEV_W-1:0]     r_dev;
  logic [WR_W-1:0]      r_wr_n, w_wr_n_next;
  logic                 r_caret_strobe, r_caret_en;
  logic [POS_W-1:0]     r_caret_pos;
  logic                 w_pick, w_ref_hit;
  logic                 w_sel_found, w_pred_found;
  logic [POS_W-1:0]     w_sel_idx, w_pred_idx;
  pins_t                w_pins;

  hpdl_rr_pick u_sel_pick (
    .i_mask    (r_dirty),
    .i_last    (r_last),
    .o_found_c (w_sel_found),
    .o_idx_c   (w_sel_idx)
  );

  // Look-ahead pick so buf_raddr already holds the winner during the selection cycle.
  hpdl_rr_pick u_pred_pick (
    .i_mask    (w_dirty_next),
    .i_last    (r_last),
    .o_found_c (w_pred_found),
    .o_idx_c   (w_pred_idx)
  );

  generate
    if (REFRESH_CYC != 0) begin : g_refresh
      localparam int unsigned REF_W = (REFRESH_CYC > 1) ? $clog2(REFRESH_CYC) : 1;
      logic [REF_W-1:0] r_ref_cnt;

      assign w_ref_hit = (r_ref_cnt == REF_W'(REFRESH_CYC - 1));

      always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET)         r_ref_cnt <= '0;
        else if (w_ref_hit) r_ref_cnt <= '0;
        else                r_ref_cnt <= r_ref_cnt + REF_W'(1);
      end
    end else begin : g_no_refresh
      assign w_ref_hit = 1'b0;
    end
  endgenerate

  // Dirty sources; any caret move re-marks both the old and the new position.
  always_comb begin
    w_set = '0;
    if (bus.mark_valid) w_set[bus.mark_addr] = 1'b1;
    if (bus.caret_en && (bus.caret_strobe != r_caret_strobe)) w_set[bus.caret_pos] = 1'b1;
    if ((bus.caret_pos != r_caret_pos) || (bus.caret_en != r_caret_en)) begin
      w_set[bus.caret_pos] = 1'b1;
      w_set[r_caret_pos]   = 1'b1;
    end
    if (w_ref_hit) w_set = '1;
  end

  assign w_dirty_next = (r_dirty & ~w_clr) | w_set;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_clr        = '0;
    w_pick       = 1'b0;
    w_wr_n_next  = '1;
    w_raddr_next = r_buf_raddr;
    unique case (r_state)
      ST_IDLE: begin
        if (w_sel_found) begin
          w_pick            = 1'b1;
          w_clr[w_sel_idx]  = 1'b1;
          w_state_next      = ST_READ;
        end
      end
      ST_READ: begin
        w_state_next = ST_SETUP;
        w_cnt_next   = CNT_W'(SETUP_CYC - 1);
      end
      ST_SETUP: begin
        if (r_cnt == '0) begin
          w_state_next = ST_PULSE;
          w_cnt_next   = CNT_W'(PULSE_CYC - 1);
        end else begin
          w_cnt_next = r_cnt - CNT_W'(1);
        end
      end
      ST_PULSE: begin
        if (r_cnt == '0) begin
          w_state_next = ST_HOLD;
          w_cnt_next   = CNT_W'(HOLD_CYC - 1);
        end else begin
          w_cnt_next = r_cnt - CNT_W'(1);
        end
      end
      ST_HOLD: begin
        if (r_cnt == '0) w_state_next = ST_IDLE;
        else             w_cnt_next   = r_cnt - CNT_W'(1);
      end
      default: w_state_next = ST_IDLE;
    endcase
    if (w_state_next == ST_PULSE) w_wr_n_next[r_dev] = 1'b0;
    if ((w_state_next == ST_IDLE) && w_pred_found) w_raddr_next = w_pred_idx;
  end

  assign w_pins = pos_to_pins(r_last);
  assign w_chr  = (bus.caret_en && (r_last == bus.caret_pos) && !bus.caret_strobe)
                ? CARET_CHR : bus.buf_rdata;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_dirty        <= '1;
      r_last         <= POS_W'(NUM_POS - 1);
      r_buf_raddr    <= '0;
      r_hpdl_d       <= '0;
      r_hpdl_a       <= '0;
      r_dev          <= '0;
      r_wr_n         <= '1;
      r_caret_strobe <= 1'b0;
      r_caret_en     <= 1'b0;
      r_caret_pos    <= '0;
    end else begin
      r_dirty        <= w_dirty_next;
      r_buf_raddr    <= w_raddr_next;
      r_wr_n         <= w_wr_n_next;
      r_caret_strobe <= bus.caret_strobe;
      r_caret_en     <= bus.caret_en;
      r_caret_pos    <= bus.caret_pos;
      if (w_pick) r_last <= w_sel_idx;
      if (r_state == ST_READ) begin
        r_hpdl_d <= w_chr;
        r_hpdl_a <= w_pins.a;
        r_dev    <= w_pins.dev;
      end
    end
  end

  assign bus.buf_raddr = r_buf_raddr;
  assign bus.HPDL_D    = r_hpdl_d;
  assign bus.HPDL_A    = r_hpdl_a;
  assign bus.HPDL_WR_N = r_wr_n;
  assign bus.busy      = (r_state != ST_IDLE) || (|r_dirty);

endmodule

// File: tb/tb_hpdl_write_sched.sv
// Directed self-checking bench for hpdl_write_sched: scan order, write timing, caret,
// set-beats-clear, reset mid-pulse and periodic refresh.
module tb_hpdl_write_sched;

  typedef struct {
    int          cyc;
    logic [12:0] w;
  } wr_t;

  logic clk = 1'b0;
  logic rst_n;
  logic rst_r_n;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  logic [6:0] mem   [16];
  logic [6:0] mem_r [16];
  wr_t        log_m [$];
  wr_t        log_r [$];
  logic [3:0] prev_m = 4'hF;
  logic [3:0] prev_r = 4'hF;

  hpdl_write_sched_if bus ();
  hpdl_write_sched_if bus_r ();

  hpdl_write_sched #(.REFRESH_CYC(0)) dut (
    .CLK   (clk),
    .RESET (rst_n),
    .bus   (bus)
  );

  hpdl_write_sched #(.REFRESH_CYC(64)) dut_ref (
    .CLK   (clk),
    .RESET (rst_r_n),
    .bus   (bus_r)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) bus.buf_rdata   <= mem[bus.buf_raddr];
  always @(posedge clk) bus_r.buf_rdata <= mem_r[bus_r.buf_raddr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic logic [12:0] exp_w(input int p, input logic [6:0] d);
    logic [3:0] wr;
    logic [1:0] a;
    wr = 4'hF;
    wr[p / 4] = 1'b0;
    a = 2'(3 - (p % 4));
    return {wr, a, d};
  endfunction

  // Write-start monitors: log each WR_N falling edge and confirm a single strobe low.
  always @(negedge clk) begin
    if (bus.HPDL_WR_N !== 4'hF) begin
      chk("one_low_m", 32'($countones(~bus.HPDL_WR_N)), 32'd1);
      if (prev_m === 4'hF) log_m.push_back('{cyc, {bus.HPDL_WR_N, bus.HPDL_A, bus.HPDL_D}});
    end
    prev_m = bus.HPDL_WR_N;
  end

  always @(negedge clk) begin
    if (bus_r.HPDL_WR_N !== 4'hF) begin
      chk("one_low_r", 32'($countones(~bus_r.HPDL_WR_N)), 32'd1);
      if (prev_r === 4'hF) log_r.push_back('{cyc, {bus_r.HPDL_WR_N, bus_r.HPDL_A, bus_r.HPDL_D}});
    end
    prev_r = bus_r.HPDL_WR_N;
  end

  task automatic pulse_mark(input logic [3:0] a);
    bus.mark_valid = 1'b1;
    bus.mark_addr  = a;
    tick();
    bus.mark_valid = 1'b0;
  endtask

  task automatic drain(input int limit);
    int n;
    n = 0;
    tick();
    while (bus.busy === 1'b1 && n < limit) begin
      tick();
      n++;
    end
    chk("drain_idle", 32'(bus.busy), 32'd0);
  endtask

  task automatic check_scan(input string tag);
    chk({tag, "_cnt"}, 32'(log_m.size()), 32'd16);
    for (int i = 0; i < 16 && i < log_m.size(); i++) begin
      chk({tag, "_w"}, 32'(log_m[i].w), 32'(exp_w(i, mem[i])));
      if (i > 0) chk({tag, "_gap"}, 32'(log_m[i].cyc - log_m[i-1].cyc), 32'd10);
    end
  endtask

  task automatic check_log(input string tag, input int p0, input int p1, input int n);
    chk({tag, "_cnt"}, 32'(log_m.size()), 32'(n));
    if (n > 0 && log_m.size() > 0) chk({tag, "_w0"}, 32'(log_m[0].w), 32'(exp_w(p0, mem[p0])));
    if (n > 1 && log_m.size() > 1) chk({tag, "_w1"}, 32'(log_m[1].w), 32'(exp_w(p1, mem[p1])));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    string s;
    s = "HELLO WORLD 1234";
    for (int i = 0; i < 16; i++) begin
      mem[i]   = 7'(s[i]);
      mem_r[i] = 7'(s[i]);
    end
    rst_n = 1'b0;
    rst_r_n = 1'b0;
    bus.mark_valid = 1'b0;   bus.mark_addr = '0;
    bus.caret_en = 1'b0;     bus.caret_pos = '0;    bus.caret_strobe = 1'b0;
    bus_r.mark_valid = 1'b0; bus_r.mark_addr = '0;
    bus_r.caret_en = 1'b0;   bus_r.caret_pos = '0;  bus_r.caret_strobe = 1'b0;

    // Reset values
    tick();
    chk("rst_wrn", 32'(bus.HPDL_WR_N), 32'hF);
    chk("rst_d", 32'(bus.HPDL_D), 32'h0);
    chk("rst_a", 32'(bus.HPDL_A), 32'h0);
    chk("rst_raddr", 32'(bus.buf_raddr), 32'h0);
    chk("rst_busy", 32'(bus.busy), 32'h1);
    tick();
    rst_n = 1'b1;
    rst_r_n = 1'b1;

    // Full scan after reset
    drain(300);
    check_scan("scan");
    if (log_m.size() > 5) chk("scan_pos5", 32'(log_m[5].w), 32'({4'b1101, 2'b10, 7'h20}));

    // Single mark on position 9 with exact cycle timing
    log_m.delete();
    mem[9] = 7'h41;
    pulse_mark(4'd9);
    for (int c = 1; c <= 11; c++) begin
      if (c == 1) chk("t2_raddr", 32'(bus.buf_raddr), 32'd9);
      chk("t2_wrn", 32'(bus.HPDL_WR_N), (c >= 5 && c <= 8) ? 32'hB : 32'hF);
      if (c >= 3) begin
        chk("t2_d", 32'(bus.HPDL_D), 32'h41);
        chk("t2_a", 32'(bus.HPDL_A), 32'h2);
      end else begin
        chk("t2_d_old", 32'(bus.HPDL_D), 32'h34);
      end
      chk("t2_busy", 32'(bus.busy), (c <= 10) ? 32'd1 : 32'd0);
      if (c < 11) tick();
    end

    // Wrap-around search while 15 is in flight
    log_m.delete();
    pulse_mark(4'd15);
    pulse_mark(4'd3);
    pulse_mark(4'd14);
    pulse_mark(4'd1);
    drain(100);
    chk("t3_cnt", 32'(log_m.size()), 32'd4);
    if (log_m.size() == 4) begin
      chk("t3_w0", 32'(log_m[0].w), 32'(exp_w(15, mem[15])));
      chk("t3_w1", 32'(log_m[1].w), 32'(exp_w(1, mem[1])));
      chk("t3_w2", 32'(log_m[2].w), 32'(exp_w(3, mem[3])));
      chk("t3_w3", 32'(log_m[3].w), 32'(exp_w(14, mem[14])));
    end

    // Caret
    log_m.delete();
    bus.caret_pos = 4'd7;
    drain(100);
    check_log("t4_move", 0, 7, 2);
    log_m.delete();
    bus.caret_strobe = 1'b1;
    tick(); tick(); tick();
    chk("t4_gated", 32'(bus.busy), 32'd0);
    bus.caret_en = 1'b1;
    drain(100);
    check_log("t4_en", 7, 7, 1);
    log_m.delete();
    bus.caret_strobe = 1'b0;
    drain(100);
    chk("t4_show_cnt", 32'(log_m.size()), 32'd1);
    if (log_m.size() > 0) chk("t4_show", 32'(log_m[0].w), 32'({4'b1101, 2'b00, 7'h5F}));
    log_m.delete();
    bus.caret_strobe = 1'b1;
    drain(100);
    chk("t4_hide_cnt", 32'(log_m.size()), 32'd1);
    if (log_m.size() > 0) chk("t4_hide", 32'(log_m[0].w), 32'({4'b1101, 2'b00, 7'h4F}));
    bus.caret_en = 1'b0;
    bus.caret_pos = 4'd0;
    bus.caret_strobe = 1'b0;
    drain(100);

    // Mark in the cycle the position is selected: written twice
    log_m.delete();
    pulse_mark(4'd4);
    pulse_mark(4'd4);
    drain(100);
    check_log("t5", 4, 4, 2);

    // Reset during PULSE
    log_m.delete();
    pulse_mark(4'd2);
    tick(); tick(); tick(); tick();
    chk("t6_pulse", 32'(bus.HPDL_WR_N), 32'hE);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_wrn", 32'(bus.HPDL_WR_N), 32'hF);
    chk("t6_rst_d", 32'(bus.HPDL_D), 32'h0);
    chk("t6_rst_a", 32'(bus.HPDL_A), 32'h0);
    tick();
    rst_n = 1'b1;
    log_m.delete();
    chk("t6_busy", 32'(bus.busy), 32'd1);
    drain(300);
    check_scan("t6_scan");

    // Periodic refresh keeps re-marking: scan continues past 16 writes
    chk("ref_cnt", 32'(log_r.size() >= 20), 32'd1);
    for (int i = 0; i < 20 && i < log_r.size(); i++) begin
      chk("ref_w", 32'(log_r[i].w), 32'(exp_w(i % 16, mem_r[i % 16])));
      if (i > 0) chk("ref_gap", 32'(log_r[i].cyc - log_r[i-1].cyc), 32'd10);
    end
    chk("ref_busy", 32'(bus_r.busy), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
